// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: function codes for the ALU and
// the multiply/divide unit, plus the MDU sequencer state encoding.
package alu_pkg;

  localparam int NB_FN = 6;

  localparam logic [NB_FN-1:0] FN_SLL   = 6'b000000;
  localparam logic [NB_FN-1:0] FN_SRL   = 6'b000010;
  localparam logic [NB_FN-1:0] FN_SRA   = 6'b000011;
  localparam logic [NB_FN-1:0] FN_SLLV  = 6'b000100;
  localparam logic [NB_FN-1:0] FN_SRLV  = 6'b000110;
  localparam logic [NB_FN-1:0] FN_SRAV  = 6'b000111;
  localparam logic [NB_FN-1:0] FN_ADDU  = 6'b100001;
  localparam logic [NB_FN-1:0] FN_SUBU  = 6'b100011;
  localparam logic [NB_FN-1:0] FN_AND   = 6'b100100;
  localparam logic [NB_FN-1:0] FN_OR    = 6'b100101;
  localparam logic [NB_FN-1:0] FN_XOR   = 6'b100110;
  localparam logic [NB_FN-1:0] FN_NOR   = 6'b100111;
  localparam logic [NB_FN-1:0] FN_SLT   = 6'b101010;
  localparam logic [NB_FN-1:0] FN_SLTU  = 6'b101011;

  localparam logic [NB_FN-1:0] FN_MFHI  = 6'b010000;
  localparam logic [NB_FN-1:0] FN_MTHI  = 6'b010001;
  localparam logic [NB_FN-1:0] FN_MFLO  = 6'b010010;
  localparam logic [NB_FN-1:0] FN_MTLO  = 6'b010011;
  localparam logic [NB_FN-1:0] FN_MULT  = 6'b011000;
  localparam logic [NB_FN-1:0] FN_MULTU = 6'b011001;
  localparam logic [NB_FN-1:0] FN_DIV   = 6'b011010;
  localparam logic [NB_FN-1:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide
// on unsigned magnitudes, one step per cycle, with its own counter.
module mdu_iter #(
  parameter int NB_DATA = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 run,
  input  logic                 div,
  input  logic [NB_DATA-1:0]   a,
  input  logic [NB_DATA-1:0]   b,
  output logic [2*NB_DATA-1:0] acc,
  output logic                 last
);

  localparam int NB_CNT = $clog2(NB_DATA + 1);

  logic [NB_CNT-1:0]  cnt;
  logic [NB_DATA-1:0] hi;
  logic [NB_DATA-1:0] lo;
  logic [NB_DATA-1:0] bq;
  logic               dv;

  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   rsh;
  logic [NB_DATA-1:0] dif;
  logic               fits;
  logic [NB_DATA-1:0] hi_nx;
  logic [NB_DATA-1:0] lo_nx;

  // hi is the running partial product (multiply) or remainder (divide)
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    rsh   = {hi, lo[NB_DATA-1]};
    fits  = rsh >= {1'b0, bq};
    dif   = rsh[NB_DATA-1:0] - bq;
    hi_nx = sum[NB_DATA:1];
    lo_nx = {sum[0], lo[NB_DATA-1:1]};
    if (dv) begin
      hi_nx = fits ? dif : rsh[NB_DATA-1:0];
      lo_nx = {lo[NB_DATA-2:0], fits};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      bq  <= '0;
      dv  <= 1'b0;
    end else if (load) begin
      cnt <= NB_CNT'(NB_DATA);
      hi  <= '0;
      lo  <= a;
      bq  <= b;
      dv  <= div;
    end else if (run) begin
      cnt <= cnt - NB_CNT'(1);
      hi  <= hi_nx;
      lo  <= lo_nx;
    end
  end

  assign acc  = {hi, lo};
  assign last = cnt == NB_CNT'(1);

endmodule

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers,
// start/busy/done handshake and a combinational MFHI/MFLO read port.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_A,
  input  logic [NB_DATA-1:0] i_data_B,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic [NB_DATA-1:0] o_data
);

  localparam int MSB = NB_DATA - 1;

  mdu_state_e state, state_nx;

  logic op_mul, op_div, op_sgn;
  logic accept, md_start, last;
  logic div_r, neg_q, neg_r, dz_r, done;

  logic [NB_DATA-1:0]   a_mag, b_mag, a_raw;
  logic [NB_DATA-1:0]   hi, lo, quo, rem;
  logic [2*NB_DATA-1:0] acc, prod;

  assign op_mul = i_op == NB_OP'(FN_MULT) ||
                  i_op == NB_OP'(FN_MULTU);
  assign op_div = i_op == NB_OP'(FN_DIV) ||
                  i_op == NB_OP'(FN_DIVU);
  assign op_sgn = i_op == NB_OP'(FN_MULT) ||
                  i_op == NB_OP'(FN_DIV);

  assign accept   = i_start && state == ST_IDLE;
  assign md_start = accept && (op_mul || op_div);

  assign a_mag = (op_sgn && i_data_A[MSB]) ? -i_data_A : i_data_A;
  assign b_mag = (op_sgn && i_data_B[MSB]) ? -i_data_B : i_data_B;

  mdu_iter #(
    .NB_DATA (NB_DATA)
  ) u_iter (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (md_start),
    .run   (state == ST_RUN),
    .div   (op_div),
    .a     (a_mag),
    .b     (b_mag),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (md_start) state_nx = ST_RUN;
      ST_RUN:  if (last)     state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      done  <= 1'b0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_r  <= 1'b0;
      a_raw <= '0;
    end else begin
      done <= state == ST_FIX;
      if (md_start) begin
        div_r <= op_div;
        neg_q <= op_sgn && (i_data_A[MSB] ^ i_data_B[MSB]);
        neg_r <= op_sgn && i_data_A[MSB];
        dz_r  <= op_div && i_data_B == '0;
        a_raw <= i_data_A;
      end
    end
  end

  // remainder follows the dividend sign (truncating division)
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[MSB:0] : acc[MSB:0];
  assign rem  = neg_r ? -acc[2*NB_DATA-1:NB_DATA]
                      : acc[2*NB_DATA-1:NB_DATA];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX) begin
      if (!div_r) begin
        hi <= prod[2*NB_DATA-1:NB_DATA];
        lo <= prod[MSB:0];
      end else if (dz_r) begin
        hi <= a_raw;
        lo <= '1;
      end else begin
        hi <= rem;
        lo <= quo;
      end
    end else if (accept && i_op == NB_OP'(FN_MTHI)) begin
      hi <= i_data_A;
    end else if (accept && i_op == NB_OP'(FN_MTLO)) begin
      lo <= i_data_A;
    end
  end

  always_comb begin
    o_data = '0;
    if (i_op == NB_OP'(FN_MFHI)) o_data = hi;
    if (i_op == NB_OP'(FN_MFLO)) o_data = lo;
  end

  assign o_busy = state != ST_IDLE;
  assign o_done = done;
  assign o_hi   = hi;
  assign o_lo   = lo;

endmodule
